// File: rtl/prim_secded_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prim_secded_pkg
// Description : Shared 72/64 SECDED constants (H-matrix columns and widths)
//               used by the encoder and by the decoder syndrome logic.
// Revision    : 1.0  initial release
// ============================================================================
package prim_secded_pkg;

    localparam int SECDED_DATA_W  = 64;
    localparam int SECDED_CHECK_W = 8;
    localparam int SECDED_CODE_W  = SECDED_DATA_W + SECDED_CHECK_W;

    // Columns 0..55 are every weight-3 byte in lexicographic order of set-bit
    // indices; 56..63 are weight-5 columns so every column stays odd weight.
    localparam logic [SECDED_CHECK_W-1:0] SECDED_72_64_H [SECDED_DATA_W] = '{
        8'h07, 8'h0b, 8'h13, 8'h23, 8'h43, 8'h83,
        8'h0d, 8'h15, 8'h25, 8'h45, 8'h85,
        8'h19, 8'h29, 8'h49, 8'h89,
        8'h31, 8'h51, 8'h91,
        8'h61, 8'ha1,
        8'hc1,
        8'h0e, 8'h16, 8'h26, 8'h46, 8'h86,
        8'h1a, 8'h2a, 8'h4a, 8'h8a,
        8'h32, 8'h52, 8'h92,
        8'h62, 8'ha2,
        8'hc2,
        8'h1c, 8'h2c, 8'h4c, 8'h8c,
        8'h34, 8'h54, 8'h94,
        8'h64, 8'ha4,
        8'hc4,
        8'h38, 8'h58, 8'h98,
        8'h68, 8'ha8,
        8'hc8,
        8'h70, 8'hb0,
        8'hd0,
        8'he0,
        8'h7c, 8'had, 8'h9b, 8'h76, 8'he6, 8'h79, 8'hd3, 8'h8f
    };

endpackage
`default_nettype wire

// File: rtl/prim_secded_72_64_enc.sv
`default_nettype none
// ============================================================================
// Module      : prim_secded_72_64_enc
// Description : Combinational 72/64 SECDED encoder, {check, data} output.
// Revision    : 1.0  initial release
// ============================================================================
module prim_secded_72_64_enc
    import prim_secded_pkg::*;
(
    input  logic [SECDED_DATA_W-1:0] i_data,
    output logic [SECDED_CODE_W-1:0] o_codeword
);

    logic [SECDED_CHECK_W-1:0] w_check;

    always_comb begin
        w_check = '0;
        for (int i = 0; i < SECDED_DATA_W; i++) begin
            for (int j = 0; j < SECDED_CHECK_W; j++) begin
                w_check[j] = w_check[j] ^ (i_data[i] & SECDED_72_64_H[i][j]);
            end
        end
    end

    assign o_codeword = {w_check, i_data};

endmodule
`default_nettype wire

// File: rtl/prim_secded_72_64_enc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prim_secded_72_64_enc_pipe
// Description : Registered 72/64 SECDED encoder stage with valid/ready,
//               one-shot error injection and a saturating beat counter.
// Revision    : 1.0  initial release
// ============================================================================
module prim_secded_72_64_enc_pipe
    import prim_secded_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SECDED_DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [SECDED_CODE_W-1:0] out_data_o,
    input  logic                     inj_arm_i,
    input  logic [SECDED_CODE_W-1:0] inj_mask_i,
    output logic                     inj_pending_o,
    output logic                     inj_done_o,
    output logic [CNT_W-1:0]         enc_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic                     r_out_valid;
    logic [SECDED_CODE_W-1:0] r_out_data;
    logic                     r_inj_pending;
    logic [SECDED_CODE_W-1:0] r_inj_mask;
    logic                     r_inj_done;
    logic [CNT_W-1:0]         r_enc_cnt;

    logic                     w_accept;
    logic [SECDED_CODE_W-1:0] w_codeword;
    logic [SECDED_CODE_W-1:0] w_applied_mask;

    prim_secded_72_64_enc u_enc (
        .i_data     (in_data_i),
        .o_codeword (w_codeword)
    );

    assign in_ready_o     = !r_out_valid | out_ready_i;
    assign w_accept       = in_valid_i & in_ready_o;
    assign w_applied_mask = r_inj_pending ? r_inj_mask : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_inj_pending <= 1'b0;
            r_inj_mask    <= '0;
            r_inj_done    <= 1'b0;
            r_enc_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_codeword ^ w_applied_mask;
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end

            // A fresh arm wins over consumption so a mask armed alongside the
            // consuming beat survives for the following beat.
            if (inj_arm_i) begin
                r_inj_pending <= 1'b1;
                r_inj_mask    <= inj_mask_i;
            end else if (w_accept && r_inj_pending) begin
                r_inj_pending <= 1'b0;
            end
            r_inj_done <= w_accept & r_inj_pending;

            if (w_accept && (r_enc_cnt != c_cnt_max)) begin
                r_enc_cnt <= r_enc_cnt + 1'b1;
            end
        end
    end

    assign out_valid_o   = r_out_valid;
    assign out_data_o    = r_out_data;
    assign inj_pending_o = r_inj_pending;
    assign inj_done_o    = r_inj_done;
    assign enc_cnt_o     = r_enc_cnt;

endmodule
`default_nettype wire
